jtag_dmi_master: RTL and testbench



---
 rtl/jtag_dmi_master_pkg.sv | 35 +++
 rtl/jtag_dmi_master_tck_gen.sv | 36 +++
 rtl/jtag_dmi_master.sv | 150 +++++++++++++++
 tb/tb_jtag_dmi_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dmi_master_pkg.sv
// Shared DMI/JTAG definitions: op encodings, FSM states and the TAP walk
// (TMS per rising TCK edge) for each scan phase.
package jtag_dmi_master_pkg;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [2:0] {
    TLR_RESET,
    TO_IDLE,
    IR_SCAN,
    IDLE,
    DR_SCAN,
    RESP
  } state_e;

  // IR walk: Sel-DR, Sel-IR, Capture, enter Shift, shifts (last exits), Update, RTI.
  // DR walk: Sel-DR, Capture, enter Shift, shifts (last exits), Update, RTI.
  function automatic logic tms_pattern(input state_e st, input int idx,
                                       input int ir_bits, input int sr_bits);
    logic t;
    t = 1'b0;
    case (st)
      TLR_RESET: t = 1'b1;
      IR_SCAN:   t = (idx < 2) || (idx == 4 + ir_bits - 1) || (idx == 4 + ir_bits);
      DR_SCAN:   t = (idx == 0) || (idx == 3 + sr_bits - 1) || (idx == 3 + sr_bits);
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jtag_dmi_master_tck_gen.sv
// TCK divider: toggles every CLK_DIV clk while enabled, with one-clk strobes
// asserted in the cycle whose closing clk edge makes TCK rise or fall.
module jtag_dmi_master_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  logic [7:0] cnt;
  logic       last;

  assign last     = (cnt == 8'(CLK_DIV - 1));
  assign tck_rise = en && last && !tck;
  assign tck_fall = en && last && tck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_dmi_master.sv
// Host-side JTAG initiator: resets the TAP, loads the DMI IR once, then turns each
// accepted DMI request into a 45-edge DR scan; one request in flight, req_ready low while scanning.
module jtag_dmi_master
  import jtag_dmi_master_pkg::*;
#(
  parameter int                 DMI_ADDR_BITS = 6,
  parameter int                 DMI_DATA_BITS = 32,
  parameter int                 DMI_OP_BITS   = 2,
  parameter int                 IR_BITS       = 5,
  parameter logic [IR_BITS-1:0] DMI_IR        = 5'h11,
  parameter int                 CLK_DIV       = 2,
  parameter int                 RESET_TCKS    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DMI_ADDR_BITS-1:0] req_addr,
  input  logic [DMI_DATA_BITS-1:0] req_data,
  input  logic [DMI_OP_BITS-1:0]   req_op,
  output logic                     resp_valid,
  output logic [DMI_DATA_BITS-1:0] resp_data,
  output logic [DMI_OP_BITS-1:0]   resp_op,
  output logic                     busy,
  output logic                     jtag_TCK,
  output logic                     jtag_TMS,
  output logic                     jtag_TDI,
  input  logic                     jtag_TDO
);

  localparam int SR_BITS = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam int IR_LEN  = 4 + IR_BITS + 2;
  localparam int DR_LEN  = 3 + SR_BITS + 2;
  localparam int MAX_LEN = (DR_LEN > RESET_TCKS) ? DR_LEN : RESET_TCKS;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SR_BITS-1:0]       sr_q, sr_d;
  logic                     tms_q, tms_d;
  logic                     tdi_q, tdi_d;
  logic [DMI_DATA_BITS-1:0] rdata_q, rdata_d;
  logic [DMI_OP_BITS-1:0]   rop_q, rop_d;
  logic                     tck_rise, tck_fall;
  logic [IR_BITS-1:0]       ir_rem;
  int                       idx;

  function automatic int seq_len(input state_e s);
    case (s)
      TLR_RESET: return RESET_TCKS;
      TO_IDLE:   return 1;
      IR_SCAN:   return IR_LEN;
      default:   return DR_LEN;
    endcase
  endfunction

  jtag_dmi_master_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .tck      (jtag_TCK),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign req_ready  = (state_q == IDLE) || (state_q == RESP);
  assign busy       = !req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = rdata_q;
  assign resp_op    = rop_q;
  assign jtag_TMS   = tms_q;
  assign jtag_TDI   = tdi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TLR_RESET;
      cnt_q   <= '0;
      sr_q    <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      rdata_q <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      rdata_q <= rdata_d;
      rop_q   <= rop_d;
    end
  end

  // cnt_q counts rising edges completed in the current phase; pins for the
  // next rising edge are set up on the preceding falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    rdata_d = rdata_q;
    rop_d   = rop_q;
    idx     = int'(cnt_q);
    ir_rem  = DMI_IR >> (idx - 4);
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req_valid && req_ready) begin
          state_d = DR_SCAN;
          cnt_d   = '0;
          sr_d    = {req_addr, req_data, req_op};
          tms_d   = tms_pattern(DR_SCAN, 0, IR_BITS, SR_BITS);
          tdi_d   = 1'b0;
        end
      end
      default: begin
        if (tck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == DR_SCAN && idx >= 3 && idx < 3 + SR_BITS)
            sr_d = {jtag_TDO, sr_q[SR_BITS-1:1]};
        end else if (tck_fall) begin
          if (idx == seq_len(state_q)) begin
            cnt_d = '0;
            tdi_d = 1'b0;
            case (state_q)
              TLR_RESET: state_d = TO_IDLE;
              TO_IDLE:   state_d = IR_SCAN;
              IR_SCAN:   state_d = IDLE;
              default: begin
                state_d = RESP;
                rdata_d = sr_q[DMI_OP_BITS +: DMI_DATA_BITS];
                rop_d   = sr_q[DMI_OP_BITS-1:0];
              end
            endcase
            tms_d = tms_pattern(state_d, 0, IR_BITS, SR_BITS);
          end else begin
            tms_d = tms_pattern(state_q, idx, IR_BITS, SR_BITS);
            tdi_d = 1'b0;
            if (state_q == IR_SCAN && idx >= 4 && idx < 4 + IR_BITS)
              tdi_d = ir_rem[0];
            if (state_q == DR_SCAN && idx >= 3 && idx < 3 + SR_BITS)
              tdi_d = sr_q[0];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Bench for jtag_dmi_master: TDO loops back TDI delayed by one TCK rising edge,
// pins are logged per rising edge and responses are predicted from the sent words.
module tb_jtag_dmi_master;
  import jtag_dmi_master_pkg::*;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_op = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data;
  logic [1:0]  resp_op;
  logic        jtag_TCK, jtag_TMS, jtag_TDI;
  logic        tdo_r;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  logic        tms_q[$];
  logic        tdi_q[$];
  logic [39:0] exp_q[$];
  logic        prev_rv;
  logic [33:0] last_resp;
  logic [39:0] cmp_w, cmp_c;

  always #5 clk = ~clk;

  jtag_dmi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_op    (resp_op),
    .busy       (busy),
    .jtag_TCK   (jtag_TCK),
    .jtag_TMS   (jtag_TMS),
    .jtag_TDI   (jtag_TDI),
    .jtag_TDO   (tdo_r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Echo target: the word comes back one bit higher, bit 0 is the idle-low TDI of the capture edge.
  function automatic logic [39:0] loopback(input logic [39:0] w);
    return {w[38:0], 1'b0};
  endfunction

  always @(posedge jtag_TCK or posedge rst)
    if (rst) tdo_r <= 1'b0;
    else     tdo_r <= jtag_TDI;

  always @(posedge jtag_TCK) begin
    tms_q.push_back(jtag_TMS);
    tdi_q.push_back(jtag_TDI);
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_rv   = 1'b0;
      last_resp = '0;
    end else begin
      chk("ready_vs_busy", req_ready, !busy);
      if (req_ready) chk("tck_idle_low", jtag_TCK, 1'b0);
      if (resp_valid) begin
        resp_cnt++;
        chk("resp_width", prev_rv, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got response %0d expected none", resp_cnt);
        end else begin
          cmp_w = exp_q.pop_front();
          cmp_c = loopback(cmp_w);
          chk("resp_data", resp_data, cmp_c[33:2]);
          chk("resp_op", resp_op, cmp_c[1:0]);
        end
        last_resp = {resp_data, resp_op};
      end else begin
        chk("resp_hold", {resp_data, resp_op}, last_resp);
      end
      prev_rv = resp_valid;
    end
  end

  task automatic wait_ready(input int max, output int cyc);
    cyc = 0;
    while (!req_ready && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_timeout", req_ready, 1'b1);
  endtask

  task automatic wait_resp(input int target, input int max);
    int n = 0;
    while (resp_cnt < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", resp_cnt >= target, 1'b1);
  endtask

  task automatic send(input logic [5:0] a, input logic [31:0] d, input logic [1:0] o,
                      input bit expect_resp);
    int cyc;
    req_addr  = a;
    req_data  = d;
    req_op    = o;
    req_valid = 1'b1;
    wait_ready(1000, cyc);
    if (expect_resp) exp_q.push_back({a, d, o});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 6'h2A;
    req_data  = $urandom;
    req_op    = 2'd3;
  endtask

  task automatic check_init(input string tag);
    logic [63:0] tv, dv;
    tv = '0;
    dv = '0;
    chk({tag, "_edges"}, tms_q.size(), 18);
    for (int i = 0; i < tms_q.size() && i < 64; i++) begin
      tv[i] = tms_q[i];
      dv[i] = tdi_q[i];
    end
    chk({tag, "_tms"}, tv, 64'h1_81BF);
    chk({tag, "_tdi"}, dv, 64'h8800);
    tms_q.delete();
    tdi_q.delete();
  endtask

  task automatic check_dr(input string tag, input logic [39:0] word);
    logic [63:0] tv, dv;
    tv = '0;
    dv = '0;
    chk({tag, "_edges"}, tms_q.size(), 45);
    for (int i = 0; i < tms_q.size() && i < 64; i++) begin
      tv[i] = tms_q[i];
      dv[i] = tdi_q[i];
    end
    chk({tag, "_tms"}, tv, 64'h0000_0C00_0000_0001);
    chk({tag, "_tdi"}, dv, 64'(word) << 3);
    tms_q.delete();
    tdi_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base;
    logic [5:0]  b_addr[3] = '{6'h01, 6'h22, 6'h3F};
    logic [31:0] b_data[3] = '{32'h0000_00FF, 32'h8000_0001, 32'hCAFE_F00D};
    logic [1:0]  b_op[3]   = '{DMI_WRITE, DMI_READ, DMI_NOP};

    repeat (3) @(negedge clk);
    chk("rst_tck", jtag_TCK, 1'b0);
    chk("rst_tms", jtag_TMS, 1'b1);
    chk("rst_tdi", jtag_TDI, 1'b0);
    chk("rst_ready_busy_valid", {req_ready, busy, resp_valid}, 3'b010);
    chk("rst_resp", {resp_data, resp_op}, 34'h0);

    rst = 1'b0;
    wait_ready(400, cyc);
    chk("init_cycles", cyc, 36 * CLK_DIV);
    check_init("init");

    // Write addr 0x10 data 1: TDI word 0x40_0000_0006, echo gives data 3, op 0.
    send(6'h10, 32'h0000_0001, DMI_WRITE, 1'b1);
    wait_resp(1, 400);
    check_dr("wr", 40'h40_0000_0006);
    chk("wr_resp_data_lit", resp_data, 32'h0000_0003);
    chk("wr_resp_op_lit", resp_op, 2'd0);

    send(6'h05, 32'hA5A5_5A5A, DMI_READ, 1'b1);
    wait_resp(2, 400);
    check_dr("rd", {6'h05, 32'hA5A5_5A5A, 2'd1});
    chk("rd_resp_data_lit", resp_data, 32'h4B4A_B4B4);
    chk("rd_resp_op_lit", resp_op, 2'd2);

    send(6'h00, 32'h0, DMI_NOP, 1'b1);
    wait_resp(3, 400);
    check_dr("nop", 40'h0);
    chk("nop_resp_lit", {resp_data, resp_op}, 34'h0);

    // req_valid stays high through three scans; only ready cycles may latch.
    base = resp_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = b_addr[i];
      req_data = b_data[i];
      req_op   = b_op[i];
      wait_ready(1000, cyc);
      exp_q.push_back({b_addr[i], b_data[i], b_op[i]});
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_resp(base + 3, 1000);
    repeat (10) @(negedge clk);
    chk("b2b_pulses", resp_cnt - base, 3);
    chk("b2b_edges", tms_q.size(), 135);
    tms_q.delete();
    tdi_q.delete();

    // Abort a scan just after its 20th shift edge.
    base = resp_cnt;
    send(6'h15, 32'h1234_5678, DMI_WRITE, 1'b0);
    cyc = 0;
    while (tms_q.size() < 23 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_edge", tms_q.size(), 23);
    rst = 1'b1;
    #1;
    chk("abort_tck", jtag_TCK, 1'b0);
    chk("abort_tms", jtag_TMS, 1'b1);
    chk("abort_tdi", jtag_TDI, 1'b0);
    chk("abort_ready_busy_valid", {req_ready, busy, resp_valid}, 3'b010);
    chk("abort_resp", {resp_data, resp_op}, 34'h0);
    repeat (2) @(negedge clk);
    tms_q.delete();
    tdi_q.delete();
    rst = 1'b0;
    wait_ready(400, cyc);
    chk("reinit_cycles", cyc, 36 * CLK_DIV);
    check_init("reinit");
    chk("abort_no_resp", resp_cnt, base);

    send(6'h3F, 32'hDEAD_BEEF, DMI_WRITE, 1'b1);
    wait_resp(base + 1, 400);
    check_dr("post", {6'h3F, 32'hDEAD_BEEF, 2'd2});
    repeat (4) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
